// File: rtl/gyro_axis_monitor.sv
// gyro_axis_monitor: per-axis offset calibration, saturating correction, moving average, peak hold and LED display.
// Optional deadband on the corrected sample is enabled by defining GYRO_DEADBAND_EN.
module gyro_axis_monitor #(
    parameter int N_AXES   = 3,
    parameter int DATA_W   = 16,
    parameter int CAL_LOG2 = 4,
    parameter int AVG_LOG2 = 2,
    parameter int LED_W    = 16,
    parameter int DEADBAND = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic [N_AXES*DATA_W-1:0]   sample_data,
    input  logic                       cal_req,
    input  logic [$clog2(N_AXES)-1:0]  sel,
    input  logic [1:0]                 mode,
    output logic [LED_W-1:0]           led,
    output logic                       cal_done,
    output logic                       out_valid
);
    localparam int SW   = $clog2(N_AXES);
    localparam int AW   = DATA_W + CAL_LOG2;
    localparam int D    = 2 ** AVG_LOG2;
    localparam int SUMW = DATA_W + AVG_LOG2;
    localparam int SH   = DATA_W - 1 - $clog2(LED_W);
    localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    if (LED_W > DATA_W || DEADBAND < 0) begin : g_bad_params
        $error("gyro_axis_monitor: invalid parameters");
    end

    typedef enum logic {CAL, RUN} state_t;
    state_t state, state_nx;

    logic [CAL_LOG2-1:0]      cnt;
    logic                     v1, r1;
    logic signed [AW-1:0]     acc [N_AXES];
    logic signed [AW-1:0]     acc_nx [N_AXES];
    logic signed [DATA_W-1:0] smp [N_AXES];
    logic signed [DATA_W:0]   diff [N_AXES];
    logic signed [DATA_W-1:0] corr_c [N_AXES];
    logic signed [DATA_W-1:0] offset [N_AXES];
    logic signed [DATA_W-1:0] s1 [N_AXES];
    logic signed [DATA_W-1:0] corr1 [N_AXES];
    logic signed [DATA_W-1:0] raw [N_AXES];
    logic signed [DATA_W-1:0] filt [N_AXES];
    logic signed [DATA_W-1:0] filt_nx [N_AXES];
    logic signed [DATA_W-1:0] peak [N_AXES];
    logic signed [DATA_W-1:0] peak_nx [N_AXES];
    logic signed [DATA_W-1:0] win [N_AXES][D];
    logic signed [SUMW-1:0]   sum [N_AXES];
    logic signed [SUMW-1:0]   sum_nx [N_AXES];
    logic [SW-1:0]            sc;
    logic [DATA_W-1:0]        fa, mag;
    logic [LED_W-1:0]         bar, led_nx;

    function automatic logic signed [DATA_W-1:0] sabs(input logic signed [DATA_W-1:0] x);
        return (x == SMIN) ? SMAX : (x < 0) ? -x : x;
    endfunction

    assign cal_done = (state == RUN);

    always_comb begin
        state_nx = cal_req ? CAL : (state == CAL && sample_valid && &cnt) ? RUN : state;
    end

    always_comb begin
        for (int k = 0; k < N_AXES; k++) begin
            smp[k]     = sample_data[k*DATA_W +: DATA_W];
            acc_nx[k]  = acc[k] + smp[k];
            diff[k]    = smp[k] - offset[k];
            corr_c[k]  = (diff[k][DATA_W] != diff[k][DATA_W-1]) ? (diff[k][DATA_W] ? SMIN : SMAX)
                                                                : diff[k][DATA_W-1:0];
`ifdef GYRO_DEADBAND_EN
            corr_c[k]  = (corr_c[k] >= -DEADBAND && corr_c[k] <= DEADBAND) ? '0 : corr_c[k];
`endif
            sum_nx[k]  = sum[k] + corr1[k] - win[k][D-1];
            filt_nx[k] = sum_nx[k][AVG_LOG2 +: DATA_W];
            peak_nx[k] = (sabs(filt_nx[k]) > peak[k]) ? sabs(filt_nx[k]) : peak[k];
        end
    end

    // Out-of-range selects clamp to the last axis.
    always_comb begin
        sc  = (32'(sel) >= N_AXES) ? SW'(N_AXES - 1) : sel;
        fa  = sabs(filt[sc]);
        mag = fa >> SH;
        bar = '0;
        for (int i = 0; i < LED_W; i++) bar[i] = (DATA_W'(i) < mag);
        led_nx = (mode == 2'd0) ? raw[sc][DATA_W-1 -: LED_W] :
                 (mode == 2'd1) ? filt[sc][DATA_W-1 -: LED_W] :
                 (mode == 2'd2) ? bar : peak[sc][DATA_W-1 -: LED_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CAL;
            cnt       <= '0;
            v1        <= 1'b0;
            r1        <= 1'b0;
            out_valid <= 1'b0;
            led       <= '0;
            for (int k = 0; k < N_AXES; k++) begin
                acc[k]    <= '0;
                offset[k] <= '0;
                s1[k]     <= '0;
                corr1[k]  <= '0;
                raw[k]    <= '0;
                filt[k]   <= '0;
                peak[k]   <= '0;
                sum[k]    <= '0;
                for (int j = 0; j < D; j++) win[k][j] <= '0;
            end
        end else begin
            state     <= state_nx;
            v1        <= sample_valid && !cal_req;
            r1        <= (state == RUN);
            out_valid <= v1 && r1 && !cal_req;
            led       <= led_nx;
            for (int k = 0; k < N_AXES; k++) begin
                s1[k]    <= smp[k];
                corr1[k] <= corr_c[k];
                if (v1) raw[k] <= s1[k];
            end
            if (cal_req) begin
                cnt <= '0;
                for (int k = 0; k < N_AXES; k++) begin
                    acc[k]    <= '0;
                    offset[k] <= '0;
                    filt[k]   <= '0;
                    peak[k]   <= '0;
                    sum[k]    <= '0;
                    for (int j = 0; j < D; j++) win[k][j] <= '0;
                end
            end else begin
                if (state == CAL && sample_valid) begin
                    cnt <= cnt + 1'b1;
                    for (int k = 0; k < N_AXES; k++) begin
                        acc[k] <= (&cnt) ? '0 : acc_nx[k];
                        if (&cnt) offset[k] <= acc_nx[k][CAL_LOG2 +: DATA_W];
                    end
                end
                // Only samples that entered the pipeline while in RUN reach the filter.
                if (v1 && r1) begin
                    for (int k = 0; k < N_AXES; k++) begin
                        win[k][0] <= corr1[k];
                        for (int j = 1; j < D; j++) win[k][j] <= win[k][j-1];
                        sum[k]  <= sum_nx[k];
                        filt[k] <= filt_nx[k];
                        peak[k] <= peak_nx[k];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gyro_axis_monitor.sv
// tb_gyro_axis_monitor: scoreboard bench; a reference model queues expected filtered LED values per sample.
module tb_gyro_axis_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [47:0] sample_data = '0;
    logic        cal_req = 1'b0;
    logic [1:0]  sel = '0;
    logic [1:0]  mode = '0;
    logic [15:0] led;
    logic        cal_done;
    logic        out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] q[$];
    logic ov_d = 1'b0;

    int m_acc[3], m_off[3], m_sum[3], m_cnt;
    int m_win[3][4];
    bit m_run;

    gyro_axis_monitor dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .cal_req(cal_req), .sel(sel), .mode(mode), .led(led), .cal_done(cal_done),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) ov_d <= 1'b0;
        else begin
            if (ov_d) begin
                if (q.size() == 0) check("spurious_out_valid", 1, 0);
                else check("filt_led", {16'h0, led}, {16'h0, q.pop_front()});
            end
            ov_d <= out_valid;
        end
    end

    task automatic mreset();
        m_run = 0;
        m_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_off[k] = 0; m_sum[k] = 0;
            for (int j = 0; j < 4; j++) m_win[k][j] = 0;
        end
    endtask

    task automatic smp(input int x, input int y, input int z);
        int v[3];
        int c, si;
        v = '{x, y, z};
        si = (sel >= 2'd3) ? 2 : int'(sel);
        sample_data = {16'(z), 16'(y), 16'(x)};
        sample_valid = 1'b1;
        if (!cal_req) begin
            if (!m_run) begin
                for (int k = 0; k < 3; k++) m_acc[k] += v[k];
                m_cnt++;
                if (m_cnt == 16) begin
                    for (int k = 0; k < 3; k++) m_off[k] = m_acc[k] >>> 4;
                    m_run = 1;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    c = v[k] - m_off[k];
                    c = (c > 32767) ? 32767 : (c < -32768) ? -32768 : c;
`ifdef GYRO_DEADBAND_EN
                    if (c >= -8 && c <= 8) c = 0;
`endif
                    m_sum[k] += c - m_win[k][3];
                    for (int j = 3; j > 0; j--) m_win[k][j] = m_win[k][j-1];
                    m_win[k][0] = c;
                end
                q.push_back(16'(m_sum[si] >>> 2));
            end
        end
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    task automatic calib(input int x, input int y, input int z);
        for (int i = 0; i < 16; i++) begin
            smp(x, y, z);
            if (i == 14) check("cal_done_after15", {31'h0, cal_done}, 0);
        end
        check("cal_done_after16", {31'h0, cal_done}, 1);
    endtask

    task automatic do_cal(input int x);
        cal_req = 1'b1;
        smp(x, 0, 0);
        cal_req = 1'b0;
        mreset();
        check("cal_req_drops_done", {31'h0, cal_done}, 0);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1 check("queue_drained", q.size(), 0);
    endtask

    task automatic settle(input logic [15:0] exp, input string tag);
        repeat (2) @(posedge clk);
        #1 check(tag, {16'h0, led}, {16'h0, exp});
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mreset();
        #23;
        check("rst_led", {16'h0, led}, 0);
        check("rst_cal_done", {31'h0, cal_done}, 0);
        check("rst_out_valid", {31'h0, out_valid}, 0);
        @(posedge clk); #1 rst = 1'b1;

        calib(100, -50, 0);
        mode = 2'd1; sel = 2'd0;
        for (int i = 0; i < 4; i++) smp(100, -50, 0);
        drain();
        check("t1_led_zero", {16'h0, led}, 0);
        mode = 2'd0; sel = 2'd1;
        settle(16'hFFCE, "t1_raw_y");

        mode = 2'd1; sel = 2'd0;
        do_cal(1600);
        calib(0, 0, 0);
        for (int i = 0; i < 4; i++) smp(400, 0, 0);
        drain();
        check("t2_led", {16'h0, led}, 32'h0190);

        do_cal(0);
        calib(-32768, 0, 0);
        for (int i = 0; i < 4; i++) smp(32767, 0, 0);
        drain();
        check("t3_filt_sat", {16'h0, led}, 32'h7FFF);
        mode = 2'd2;
        settle(16'h7FFF, "t3_bar_full");

        mode = 2'd1; sel = 2'd3;
        do_cal(0);
        calib(0, 0, 0);
        for (int i = 0; i < 4; i++) smp(0, 0, -4096);
        drain();
        mode = 2'd2;
        settle(16'h0003, "t4_bar_neg_sel3");

        mode = 2'd1; sel = 2'd0;
        do_cal(0);
        calib(0, 0, 0);
        for (int i = 0; i < 4; i++) smp(300, 0, 0);
        for (int i = 0; i < 4; i++) smp(100, 0, 0);
        drain();
        mode = 2'd3;
        settle(16'h012C, "t5_peak_hold");
        do_cal(0);
        settle(16'h0000, "t5_peak_cleared");

        mode = 2'd1;
        calib(0, 0, 0);
        for (int i = 0; i < 4; i++) smp(5, 0, 0);
        drain();
        smp(400, 0, 0);
        smp(400, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_led", {16'h0, led}, 0);
        check("t6_rst_cal_done", {31'h0, cal_done}, 0);
        check("t6_rst_out_valid", {31'h0, out_valid}, 0);
        q.delete();
        mreset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("t6_post_rst_cal", {31'h0, cal_done}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
